// File: rtl/hello_merger.sv
// hello_merger: packet-level 3:1 arbiter merging SRIO HELLO streams toward the SRIO core TX port.
// Latency: one IDLE arbitration bubble per packet, then a beat accepted in cycle n appears on M_AXIS in cycle n+1.
// Backpressure: a single output register; S{g}_TREADY = !out_valid | M_AXIS_TREADY, so at most one beat is buffered.
//
// Ports:
//   AXIS_ACLK / AXIS_ARESETN        clock, asynchronous active-low reset
//   S0/S1/S2_AXIS_*                 sources (0 = adi chain, 1 = srio_fifo, 2 = srio_dma); FTYPE in TDATA[55:52] of first beat
//   M_AXIS_*                        merged registered stream; M_AXIS_TID is the source index of the presented beat
//   ftype_err                       one-cycle pulse per dropped packet
// Parameter FIXED_PRIO: 0 = round-robin, 1 = fixed priority (port 0 highest).
// Optional macro HELLO_FTYPE_CHECK_EN: drop packets whose first-beat FTYPE is not one of 2,5,6,8,9,10,11,13.
module hello_merger #(
   parameter int FIXED_PRIO = 0
) (
   input  logic        AXIS_ACLK,
   input  logic        AXIS_ARESETN,
   input  logic        S0_AXIS_TVALID,
   output logic        S0_AXIS_TREADY,
   input  logic [63:0] S0_AXIS_TDATA,
   input  logic        S0_AXIS_TLAST,
   input  logic [31:0] S0_AXIS_TUSER,
   input  logic        S1_AXIS_TVALID,
   output logic        S1_AXIS_TREADY,
   input  logic [63:0] S1_AXIS_TDATA,
   input  logic        S1_AXIS_TLAST,
   input  logic [31:0] S1_AXIS_TUSER,
   input  logic        S2_AXIS_TVALID,
   output logic        S2_AXIS_TREADY,
   input  logic [63:0] S2_AXIS_TDATA,
   input  logic        S2_AXIS_TLAST,
   input  logic [31:0] S2_AXIS_TUSER,
   output logic        M_AXIS_TVALID,
   input  logic        M_AXIS_TREADY,
   output logic [63:0] M_AXIS_TDATA,
   output logic        M_AXIS_TLAST,
   output logic [31:0] M_AXIS_TUSER,
   output logic [1:0]  M_AXIS_TID,
   output logic        ftype_err
);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t      state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic [1:0]  last_grant_q, last_grant_d;
   logic        first_q, first_d;       // next accepted beat is the packet's first
   logic        drop_q, drop_d;         // rest of the current packet is being discarded
   logic        out_vld_q, out_vld_d;
   logic [63:0] out_dat_q, out_dat_d;
   logic        out_last_q, out_last_d;
   logic [31:0] out_user_q, out_user_d;
   logic [1:0]  out_tid_q, out_tid_d;
   logic        ftype_err_q, ftype_err_d;

   logic [2:0]  s_vld;
   logic        sel_vld, sel_last, sel_rdy;
   logic [63:0] sel_dat;
   logic [31:0] sel_user;
   logic [1:0]  arb_g;
   logic        ftype_bad, drop_beat, s_xfr, m_xfr;

   assign s_vld = {S2_AXIS_TVALID, S1_AXIS_TVALID, S0_AXIS_TVALID};

   always_comb begin
      sel_vld  = S0_AXIS_TVALID;
      sel_dat  = S0_AXIS_TDATA;
      sel_last = S0_AXIS_TLAST;
      sel_user = S0_AXIS_TUSER;
      case (grant_q)
         2'd1: begin
            sel_vld  = S1_AXIS_TVALID;
            sel_dat  = S1_AXIS_TDATA;
            sel_last = S1_AXIS_TLAST;
            sel_user = S1_AXIS_TUSER;
         end
         2'd2: begin
            sel_vld  = S2_AXIS_TVALID;
            sel_dat  = S2_AXIS_TDATA;
            sel_last = S2_AXIS_TLAST;
            sel_user = S2_AXIS_TUSER;
         end
         default: ;
      endcase
   end

   // Only meaningful while some source is valid; round-robin starts after last_grant.
   always_comb begin
      arb_g = 2'd0;
      if (FIXED_PRIO != 0) begin
         if (s_vld[0])      arb_g = 2'd0;
         else if (s_vld[1]) arb_g = 2'd1;
         else               arb_g = 2'd2;
      end else begin
         case (last_grant_q)
            2'd0:    arb_g = s_vld[1] ? 2'd1 : (s_vld[2] ? 2'd2 : 2'd0);
            2'd1:    arb_g = s_vld[2] ? 2'd2 : (s_vld[0] ? 2'd0 : 2'd1);
            default: arb_g = s_vld[0] ? 2'd0 : (s_vld[1] ? 2'd1 : 2'd2);
         endcase
      end
   end

`ifdef HELLO_FTYPE_CHECK_EN
   always_comb begin
      case (sel_dat[55:52])
         4'd2, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd13: ftype_bad = 1'b0;
         default:                                           ftype_bad = 1'b1;
      endcase
   end
`else
   assign ftype_bad = 1'b0;
`endif

   // A dropped beat never touches the output register, so it is accepted regardless of downstream stall.
   assign drop_beat = drop_q | (first_q & ftype_bad);
   assign m_xfr     = out_vld_q & M_AXIS_TREADY;
   assign sel_rdy   = (state_q == ST_BUSY) & (drop_beat | ~out_vld_q | M_AXIS_TREADY);
   assign s_xfr     = sel_rdy & sel_vld;

   assign S0_AXIS_TREADY = sel_rdy & (grant_q == 2'd0);
   assign S1_AXIS_TREADY = sel_rdy & (grant_q == 2'd1);
   assign S2_AXIS_TREADY = sel_rdy & (grant_q == 2'd2);

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      first_d      = first_q;
      drop_d       = drop_q;
      out_vld_d    = out_vld_q;
      out_dat_d    = out_dat_q;
      out_last_d   = out_last_q;
      out_user_d   = out_user_q;
      out_tid_d    = out_tid_q;
      ftype_err_d  = s_xfr & first_q & ftype_bad;

      case (state_q)
         ST_IDLE: begin
            if (|s_vld) begin
               grant_d = arb_g;
               first_d = 1'b1;
               drop_d  = 1'b0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (s_xfr) begin
               first_d = 1'b0;
               if (first_q & ftype_bad) drop_d = 1'b1;
               if (sel_last) begin
                  last_grant_d = grant_q;
                  drop_d       = 1'b0;
                  state_d      = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Output register drains independently of the FSM, including while IDLE arbitrates.
      if (s_xfr && !drop_beat) begin
         out_vld_d  = 1'b1;
         out_dat_d  = sel_dat;
         out_last_d = sel_last;
         out_user_d = sel_user;
         out_tid_d  = grant_q;
      end else if (m_xfr) begin
         out_vld_d  = 1'b0;
      end
   end

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state_q      <= ST_IDLE;
         grant_q      <= 2'd0;
         last_grant_q <= 2'd2;
         first_q      <= 1'b0;
         drop_q       <= 1'b0;
         out_vld_q    <= 1'b0;
         out_dat_q    <= '0;
         out_last_q   <= 1'b0;
         out_user_q   <= '0;
         out_tid_q    <= 2'd0;
         ftype_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         first_q      <= first_d;
         drop_q       <= drop_d;
         out_vld_q    <= out_vld_d;
         out_dat_q    <= out_dat_d;
         out_last_q   <= out_last_d;
         out_user_q   <= out_user_d;
         out_tid_q    <= out_tid_d;
         ftype_err_q  <= ftype_err_d;
      end
   end

   assign M_AXIS_TVALID = out_vld_q;
   assign M_AXIS_TDATA  = out_dat_q;
   assign M_AXIS_TLAST  = out_last_q;
   assign M_AXIS_TUSER  = out_user_q;
   assign M_AXIS_TID    = out_tid_q;
   assign ftype_err     = ftype_err_q;

endmodule

// File: tb/tb_hello_merger.sv
// tb_hello_merger: randomized scoreboard bench for hello_merger (round-robin instance plus a fixed-priority instance).
// Expected beats are queued per source at issue time; a monitor pops them as M_AXIS transfers occur.
// Arbitration order, latency, stall stability and FTYPE drop counts come from a behavioural model in the bench.
module tb_hello_merger;

`ifdef HELLO_FTYPE_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct packed {
      logic [63:0] dat;
      logic        last;
      logic [31:0] user;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        s_vld [3];
   logic        s_rdy [3];
   logic [63:0] s_dat [3];
   logic        s_last [3];
   logic [31:0] s_user [3];
   logic        tb_drop [3];
   logic        m_vld, m_rdy, m_last, ferr;
   logic [63:0] m_dat;
   logic [31:0] m_user;
   logic [1:0]  m_tid;

   logic        f_vld [3];
   logic        f_rdy [3];
   logic [63:0] f_dat [3];
   logic        f_last [3];
   logic [31:0] f_user [3];
   logic        fm_vld, fm_last, f_err;
   logic [63:0] fm_dat;
   logic [31:0] fm_user;
   logic [1:0]  fm_tid;

   int n_chk = 0, n_fail = 0;
   int exp_err = 0, err_seen = 0, f_beats = 0;
   int m_mode = 0;
   beat_t q0[$], q1[$], q2[$];
   int order_q[$];
   logic [3:0] legal_tab [8] = '{4'd2, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd13};

   hello_merger #(.FIXED_PRIO(0)) dut (
      .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
      .S0_AXIS_TVALID(s_vld[0]), .S0_AXIS_TREADY(s_rdy[0]), .S0_AXIS_TDATA(s_dat[0]), .S0_AXIS_TLAST(s_last[0]), .S0_AXIS_TUSER(s_user[0]),
      .S1_AXIS_TVALID(s_vld[1]), .S1_AXIS_TREADY(s_rdy[1]), .S1_AXIS_TDATA(s_dat[1]), .S1_AXIS_TLAST(s_last[1]), .S1_AXIS_TUSER(s_user[1]),
      .S2_AXIS_TVALID(s_vld[2]), .S2_AXIS_TREADY(s_rdy[2]), .S2_AXIS_TDATA(s_dat[2]), .S2_AXIS_TLAST(s_last[2]), .S2_AXIS_TUSER(s_user[2]),
      .M_AXIS_TVALID(m_vld), .M_AXIS_TREADY(m_rdy), .M_AXIS_TDATA(m_dat), .M_AXIS_TLAST(m_last),
      .M_AXIS_TUSER(m_user), .M_AXIS_TID(m_tid), .ftype_err(ferr)
   );

   hello_merger #(.FIXED_PRIO(1)) dut_fixed (
      .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
      .S0_AXIS_TVALID(f_vld[0]), .S0_AXIS_TREADY(f_rdy[0]), .S0_AXIS_TDATA(f_dat[0]), .S0_AXIS_TLAST(f_last[0]), .S0_AXIS_TUSER(f_user[0]),
      .S1_AXIS_TVALID(f_vld[1]), .S1_AXIS_TREADY(f_rdy[1]), .S1_AXIS_TDATA(f_dat[1]), .S1_AXIS_TLAST(f_last[1]), .S1_AXIS_TUSER(f_user[1]),
      .S2_AXIS_TVALID(f_vld[2]), .S2_AXIS_TREADY(f_rdy[2]), .S2_AXIS_TDATA(f_dat[2]), .S2_AXIS_TLAST(f_last[2]), .S2_AXIS_TUSER(f_user[2]),
      .M_AXIS_TVALID(fm_vld), .M_AXIS_TREADY(1'b1), .M_AXIS_TDATA(fm_dat), .M_AXIS_TLAST(fm_last),
      .M_AXIS_TUSER(fm_user), .M_AXIS_TID(fm_tid), .ftype_err(f_err)
   );

   function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   function automatic bit ftype_legal(input logic [3:0] ft);
      return ft inside {4'd2, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd13};
   endfunction

   function automatic void exp_push(input int s, input beat_t b);
      case (s)
         0: q0.push_back(b);
         1: q1.push_back(b);
         default: q2.push_back(b);
      endcase
   endfunction

   function automatic int exp_size(input int s);
      case (s)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return 0;
      endcase
   endfunction

   function automatic beat_t exp_pop(input int s);
      case (s)
         0: return q0.pop_front();
         1: return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   function automatic void flush_model();
      q0.delete(); q1.delete(); q2.delete(); order_q.delete();
   endfunction

   // Drives one packet on source src; entered and left at posedge+1.
   task automatic send_pkt(input int src, input int nb, input logic [3:0] ft, input int gap);
      beat_t b;
      bit    drop;
      int    n;
      drop = CHK && !ftype_legal(ft);
      if (drop) exp_err++;
      for (int k = 0; k < nb; k++) begin
         if (k > 0 && gap > 0) begin
            s_vld[src] = 1'b0;
            repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
         end
         b.dat = {$urandom, $urandom};
         if (k == 0) b.dat[55:52] = ft;
         b.last = (k == nb - 1);
         b.user = $urandom;
         if (!drop) exp_push(src, b);
         s_dat[src] = b.dat; s_last[src] = b.last; s_user[src] = b.user;
         tb_drop[src] = drop; s_vld[src] = 1'b1;
         n = 0;
         do begin @(negedge clk); n++; end while (!s_rdy[src] && n < 500);
         if (!s_rdy[src]) begin
            n_chk++; n_fail++;
            $display("FAIL src%0d_handshake_timeout: got no TREADY after %0d cycles, expected TREADY", src, n);
            s_vld[src] = 1'b0; tb_drop[src] = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      s_vld[src] = 1'b0; tb_drop[src] = 1'b0;
   endtask

   task automatic mready_drv();
      forever begin
         @(posedge clk); #1;
         case (m_mode)
            0: m_rdy = 1'b1;
            1: m_rdy = 1'($urandom_range(0, 1));
            default: m_rdy = ~m_rdy;
         endcase
      end
   endtask

   task automatic monitor();
      logic       acc_vld = 1'b0, stall = 1'b0, in_pkt = 1'b0;
      beat_t      acc_b, st_b, eb;
      logic [1:0] acc_tid = 2'd0, st_tid = 2'd0, cur_tid = 2'd0;
      int         nacc;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            acc_vld = 1'b0; stall = 1'b0; in_pkt = 1'b0;
         end else begin
            if (ferr) err_seen++;
            if (acc_vld)
               check("latency_beat", 128'({m_vld, m_dat, m_last, m_user, m_tid}), 128'({1'b1, acc_b, acc_tid}));
            if (stall)
               check("stall_stable", 128'({m_vld, m_dat, m_last, m_user, m_tid}), 128'({1'b1, st_b, st_tid}));
            acc_vld = 1'b0; nacc = 0;
            for (int i = 0; i < 3; i++) begin
               if (s_vld[i] && s_rdy[i]) begin
                  nacc++;
                  if (!tb_drop[i]) begin
                     acc_vld = 1'b1;
                     acc_b   = '{s_dat[i], s_last[i], s_user[i]};
                     acc_tid = 2'(i);
                  end
               end
            end
            if (nacc > 0) check("single_grant", 128'(nacc), 128'(1));
            if (m_vld && !m_rdy)
               for (int i = 0; i < 3; i++)
                  if (!tb_drop[i]) check("tready_low_when_full", 128'(s_rdy[i]), 128'(0));
            stall = m_vld && !m_rdy;
            st_b  = '{m_dat, m_last, m_user};
            st_tid = m_tid;
            if (m_vld && m_rdy) begin
               if (in_pkt) check("no_interleave", 128'(m_tid), 128'(cur_tid));
               else if (order_q.size() > 0) check("arb_order", 128'(m_tid), 128'(order_q.pop_front()));
               if (exp_size(int'(m_tid)) == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected_beat: got beat tid=%0d data=%0h, expected none queued", m_tid, m_dat);
               end else begin
                  eb = exp_pop(int'(m_tid));
                  check("beat_content", 128'({m_dat, m_last, m_user}), 128'(eb));
               end
               in_pkt  = !m_last;
               cur_tid = m_tid;
            end
         end
      end
   endtask

   // Fixed-priority instance: every source always holds 2-beat packets; only port 0 may ever be served.
   task automatic fixed_run();
      logic take [3];
      int   cnt [3];
      for (int i = 0; i < 3; i++) begin
         cnt[i] = 0; f_vld[i] = 1'b0; f_last[i] = 1'b0;
         f_user[i] = 32'(i); f_dat[i] = {8'h00, 4'd6, 52'd0};
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) take[i] = f_vld[i] && f_rdy[i];
         if (rst_n && fm_vld) begin
            check("fixed_prio_tid", 128'(fm_tid), 128'(0));
            check("fixed_no_ftype_err", 128'(f_err), 128'(0));
            f_beats++;
         end
         @(posedge clk); #1;
         for (int i = 0; i < 3; i++) begin
            f_vld[i] = rst_n;
            if (take[i]) begin
               cnt[i]++;
               f_last[i] = (cnt[i] % 2 == 1);
               f_dat[i]  = {8'h00, 4'd6, 20'd0, 32'(cnt[i])};
            end
         end
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q0.size() + q1.size() + q2.size() != 0 || m_vld) && n < 3000) begin
         @(posedge clk); n++;
      end
      #1;
      check("drain_empty", 128'(q0.size() + q1.size() + q2.size()), 128'(0));
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      flush_model();
   endtask

   initial begin
      int n;
      logic [3:0] ft;
      rst_n = 1'b0; m_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_vld[i] = 1'b0; s_dat[i] = '0; s_last[i] = 1'b0; s_user[i] = '0; tb_drop[i] = 1'b0;
      end
      fork
         monitor();
         mready_drv();
         fixed_run();
      join_none
      repeat (3) @(posedge clk); #1;

      // Reset values
      check("rst_m_vld",  128'(m_vld), 128'(0));
      check("rst_m_tid",  128'(m_tid), 128'(0));
      check("rst_m_dat",  128'({m_dat, m_last, m_user}), 128'(0));
      check("rst_ferr",   128'(ferr), 128'(0));
      check("rst_tready", 128'({s_rdy[0], s_rdy[1], s_rdy[2]}), 128'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // S1 3-beat packet, downstream always ready: IDLE cycle, accept cycle, then the register stage.
      m_mode = 0;
      @(posedge clk); #1;
      fork
         send_pkt(1, 3, 4'd6, 0);
         begin
            n = 0;
            while (!m_vld && n < 20) begin @(negedge clk); n++; end
            check("first_beat_latency", 128'(n), 128'(3));
            check("first_beat_tid", 128'(m_tid), 128'(1));
         end
      join
      wait_idle();

      // Round-robin with all three sources saturated by 2-beat packets.
      pulse_reset();
      @(posedge clk); #1;
      m_mode = 1;
      for (int r = 0; r < 4; r++) begin
         order_q.push_back(0); order_q.push_back(1); order_q.push_back(2);
      end
      fork
         for (int p = 0; p < 4; p++) send_pkt(0, 2, 4'd5, 0);
         for (int p = 0; p < 4; p++) send_pkt(1, 2, 4'd8, 0);
         for (int p = 0; p < 4; p++) send_pkt(2, 2, 4'd11, 0);
      join
      wait_idle();
      check("rr_order_consumed", 128'(order_q.size()), 128'(0));

      // S2 4-beat packet under alternating downstream ready.
      m_mode = 2;
      send_pkt(2, 4, 4'd9, 0);
      wait_idle();

      // Random traffic: packet lengths, FTYPEs, intra-packet gaps and downstream ready.
      m_mode = 1;
      fork
         for (int p = 0; p < 8; p++) begin
            ft = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_tab[$urandom_range(0, 7)];
            send_pkt(0, $urandom_range(1, 4), ft, 3);
         end
         for (int p = 0; p < 8; p++) begin
            ft = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_tab[$urandom_range(0, 7)];
            send_pkt(1, $urandom_range(1, 4), ft, 3);
         end
         for (int p = 0; p < 8; p++) begin
            ft = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_tab[$urandom_range(0, 7)];
            send_pkt(2, $urandom_range(1, 4), ft, 3);
         end
      join
      wait_idle();

      // Illegal FTYPE packet followed by a legal one.
      m_mode = 0;
      send_pkt(0, 3, 4'hF, 0);
      send_pkt(0, 2, 4'd9, 0);
      wait_idle();

      // Reset while the 2nd beat of a 4-beat S0 packet is presented.
      @(posedge clk); #1;
      s_dat[0] = 64'h0050_0000_0000_0001; s_last[0] = 1'b0; s_user[0] = 32'h1; s_vld[0] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!s_rdy[0] && n < 50);
      check("mid_rst_first_accept", 128'(s_rdy[0]), 128'(1));
      @(posedge clk); #1;
      s_dat[0] = 64'hDEAD_BEEF_0000_0002; s_user[0] = 32'h2;
      check("pre_rst_m_vld", 128'(m_vld), 128'(1));
      rst_n = 1'b0;
      #1;
      check("mid_rst_m_vld",  128'(m_vld), 128'(0));
      check("mid_rst_m_out",  128'({m_dat, m_last, m_user, m_tid}), 128'(0));
      check("mid_rst_tready", 128'({s_rdy[0], s_rdy[1], s_rdy[2]}), 128'(0));
      s_vld[0] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      flush_model();
      @(posedge clk); #1;
      order_q.push_back(0); order_q.push_back(2);
      fork
         send_pkt(2, 2, 4'd2, 0);
         send_pkt(0, 2, 4'd2, 0);
      join
      wait_idle();
      check("post_rst_order_consumed", 128'(order_q.size()), 128'(0));

      check("ftype_err_pulses", 128'(err_seen), 128'(exp_err));
      check("fixed_saw_beats", 128'(f_beats > 10), 128'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hello_merger.md
Name: hello_merger

Overview:
- Three-input packet-level arbiter that merges SRIO HELLO streams into a single stream toward the SRIO core transmit port.
- Inputs: adi chain, srio_fifo and srio_dma. It is the transmit-side counterpart of the FTYPE-based TDEST router on the receive side.
- A grant is held for an entire packet (until TLAST) so beats from different sources never interleave.
- The output is registered; M_AXIS_TID identifies the source port of each beat.

Parameters:
- FIXED_PRIO, 0: arbitration mode. 0 = round-robin. 1 = fixed priority, port 0 highest and port 2 lowest.

Ports:
- AXIS_ACLK  in  1  clock
- AXIS_ARESETN  in  1  reset, asynchronous, active-low
- S0_AXIS_TVALID / S1_AXIS_TVALID / S2_AXIS_TVALID  in  1 each  source valid (0 = adi chain, 1 = srio_fifo, 2 = srio_dma)
- S0_AXIS_TREADY / S1_AXIS_TREADY / S2_AXIS_TREADY  out  1 each  source ready
- S0_AXIS_TDATA / S1_AXIS_TDATA / S2_AXIS_TDATA  in  64 each  HELLO beat; first beat carries FTYPE in [55:52]
- S0_AXIS_TLAST / S1_AXIS_TLAST / S2_AXIS_TLAST  in  1 each  end of packet
- S0_AXIS_TUSER / S1_AXIS_TUSER / S2_AXIS_TUSER  in  32 each  src/dest IDs, passed through unchanged
- M_AXIS_TVALID  out  1  merged valid
- M_AXIS_TREADY  in  1  downstream ready
- M_AXIS_TDATA  out  64  merged data
- M_AXIS_TLAST  out  1  merged last
- M_AXIS_TUSER  out  32  merged user
- M_AXIS_TID  out  2  source index of the beat currently presented
- ftype_err  out  1  one-cycle pulse per dropped packet; tied 0 without the optional feature

Behaviour:
- Reset (asynchronous assert): state = IDLE, all S*_TREADY = 0, M_AXIS_TVALID = 0, TDATA/TUSER/TLAST/TID = 0, last_grant = 2 (so port 0 wins first), ftype_err = 0. Reset in mid-packet truncates the packet; nothing is resumed after reset.
- IDLE state:
  - No S*_TREADY asserted.
  - If any S*_TVALID is high, choose grant g. Round-robin searches from last_grant+1 (wrapping 2 to 0); fixed priority takes the lowest index.
  - Register g and go to BUSY.
  - This costs exactly one bubble cycle per packet.
- BUSY state:
  - S{g}_TREADY = !out_valid | M_AXIS_TREADY; all other TREADY = 0.
  - On each s_xfr the output register loads TDATA/TLAST/TUSER and TID = g, and out_valid = 1.
  - On m_xfr without s_xfr, out_valid = 0.
  - Simultaneous m_xfr and s_xfr: the register reloads and out_valid stays 1, giving full throughput of one beat per cycle.
  - s_xfr with TLAST: last_grant = g and state returns to IDLE next cycle. The output register may still hold that last beat, and it drains while IDLE arbitrates.
- Latency: a beat accepted in cycle n appears on M_AXIS in cycle n+1.
- M_AXIS_TVALID = out_valid. Once asserted, output data is held stable until m_xfr (standard AXI-Stream).
- A single-beat packet (TLAST on the first beat) is legal: BUSY lasts one transfer.
- A source dropping TVALID mid-packet keeps the grant locked; there is no timeout.
- With M_AXIS_TREADY held low: at most one beat is buffered, then S{g}_TREADY = 0.

Optional Feature:
- Macro HELLO_FTYPE_CHECK_EN.
- Defined:
  - On the first beat of each granted packet, FTYPE = TDATA[55:52] is checked. Legal values are 2, 5, 6, 8, 9, 10, 11 and 13.
  - For an illegal value, the whole packet is consumed (S{g}_TREADY = 1 until TLAST) and nothing is written to the output register.
  - ftype_err pulses for one cycle on the first beat of the dropped packet.
  - Arbitration then continues normally.
- Not defined: no checking, all packets are forwarded, and ftype_err = 0.

Test Plan:
- After reset: all TREADY = 0, M_AXIS_TVALID = 0, TID = 0 -> then S1 sends 3 beats with FTYPE 6, M_AXIS_TREADY = 1 -> M sees 3 beats, TID = 1, TLAST on the 3rd, first beat one cycle after grant.
- S0, S1 and S2 each hold 2-beat packets continuously, FIXED_PRIO = 0 -> output TID order is 0, 1, 2, 0, 1, 2 and beats from different sources never interleave.
- Same stimulus with FIXED_PRIO = 1 -> only TID = 0 appears while S0 stays valid.
- S2 sends a 4-beat packet while M_AXIS_TREADY toggles 1010... -> no beat lost or duplicated, TDATA stable while stalled, S2_TREADY low whenever the output register is full and M_AXIS_TREADY = 0.
- AXIS_ARESETN pulsed low on the 2nd beat of a 4-beat S0 packet -> outputs clear immediately, state IDLE, next grant goes to port 0.
- With HELLO_FTYPE_CHECK_EN: S0 sends FTYPE 0xF (3 beats), then FTYPE 9 -> exactly one ftype_err pulse, only the FTYPE 9 packet appears on M.
